// File: rtl/tsconf_uart_pkg.sv
// Shared definitions for the tsconf UART receive path.
//   rx_state_t  receiver FSM states
//   OVERSAMPLE  oversample ticks per bit
//   DATA_W      width of one received character
//   baud_div()  clock divider for one oversample tick, rounded to nearest
package tsconf_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_W     = 8;

    // Round-to-nearest divide so the tick error stays within half a clock.
    function automatic int baud_div(input int clk, input int baud);
        return (clk + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Circular byte queue between the receiver FSM and the consumer.
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   push, wr_data       write strobe and byte from the receiver
//   pop                 consumer pop request (ignored when empty)
//   rd_data             head entry, forced to 0 while empty
//   empty               queue holds no bytes
//   level               occupancy, 0..DEPTH
//   overrun             one-cycle pulse: push while full without a pop
module uart_rx_fifo_mem
    import tsconf_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] store [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a push into a full queue succeeds.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gating with empty gives a clean 0 after reset without resetting storage.
    assign rd_data = empty ? '0 : store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            overrun <= push & full & ~do_pop;
        end
    end

    // NOTE: storage has no reset; only the pointers define valid contents,
    // and leaving the array unreset lets it map onto plain RAM/LUT cells.
    always_ff @(posedge clk_sys) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and a small byte FIFO.
// Ports:
//   clk_sys    system clock
//   reset      synchronous, active-high
//   rx         asynchronous serial input, idle high
//   rx_data    byte at FIFO head
//   rx_valid   FIFO non-empty
//   rx_ready   consumer pops head on rx_valid & rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: byte completed while FIFO full, byte dropped
//   rx_level   FIFO occupancy
module uart_rx_fifo
    import tsconf_uart_pkg::*;
#(
    parameter int CLK_RATE   = 84_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

    localparam int DIV = baud_div(CLK_RATE, BAUD);
    localparam int DW  = $clog2(DIV);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] TICK_RELOAD = DW'(DIV - 1);
    localparam logic [SW-1:0] SUB_MID     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SUB_LAST    = SW'(OVERSAMPLE - 1);

    logic [1:0]        sync;
    logic [2:0]        maj;
    logic              filt;
    logic [DW-1:0]     tick_cnt;
    logic              tick;

    rx_state_t         state;
    logic [SW-1:0]     sub;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              armed;
    logic              push_stb;
    logic              fifo_empty;

    // Two-flop synchroniser and a free-running tick divider; the majority
    // filter shifts on ticks only so a single-sample spike cannot start a frame.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // sees the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync     <= 2'b11;
            maj      <= 3'b111;
            tick_cnt <= TICK_RELOAD;
            tick     <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            if (tick_cnt == '0) begin
                tick_cnt <= TICK_RELOAD;
                tick     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt - 1'b1;
                tick     <= 1'b0;
            end
            if (tick) maj <= {maj[1:0], sync[1]};
        end
    end

    assign filt = (maj[0] & maj[1]) | (maj[0] & maj[2]) | (maj[1] & maj[2]);

    // Receiver FSM. After a framing error the line may sit low (break), so
    // the FSM disarms until it sees idle-high again.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            sub       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            armed     <= 1'b1;
            push_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!armed) begin
                            if (filt) armed <= 1'b1;
                        end else if (!filt) begin
                            state <= START;
                            sub   <= '0;
                        end
                    end
                    START: begin
                        if (sub == SUB_MID) begin
                            if (!filt) begin
                                state   <= DATA;
                                bit_idx <= '0;
                                sub     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sub == SUB_LAST) begin
                            shreg <= {filt, shreg[DATA_W-1:1]};
                            sub   <= '0;
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                    STOP: begin
                        if (sub == SUB_LAST) begin
                            if (filt) begin
                                push_stb <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                            state <= IDLE;
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // shreg holds the completed byte for many ticks after push_stb, so it
    // feeds the queue directly.
    uart_rx_fifo_mem #(
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push_stb),
        .wr_data (shreg),
        .pop     (rx_ready),
        .rd_data (rx_data),
        .empty   (fifo_empty),
        .level   (rx_level),
        .overrun (overrun)
    );

    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a 115200-baud instance for the
// functional and FIFO corner cases and a 31250-baud instance for skewed
// MIDI-rate frames. Received bytes are checked against a scoreboard queue.
module tb_uart_rx_fifo;
    import tsconf_uart_pkg::*;

    // 7.3728 MHz keeps the run short: 115200 -> 4 clk/tick, 31250 -> 14.75 -> 15.
    localparam int CLK_RATE = 7_372_800;
    localparam int FAST_BIT = 64;
    localparam int MIDI_BIT = 240;
    localparam int DEPTH    = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       f_reset, f_rx, f_ready, f_valid, f_ferr, f_ovr;
    logic [7:0] f_data;
    logic [2:0] f_level;
    logic       m_reset, m_rx, m_ready, m_valid, m_ferr, m_ovr;
    logic [7:0] m_data;
    logic [2:0] m_level;

    uart_rx_fifo #(.CLK_RATE(CLK_RATE), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut_f (
        .clk_sys(clk_sys), .reset(f_reset), .rx(f_rx), .rx_data(f_data),
        .rx_valid(f_valid), .rx_ready(f_ready), .frame_err(f_ferr),
        .overrun(f_ovr), .rx_level(f_level)
    );

    uart_rx_fifo #(.CLK_RATE(CLK_RATE), .BAUD(31250), .FIFO_DEPTH(DEPTH)) dut_m (
        .clk_sys(clk_sys), .reset(m_reset), .rx(m_rx), .rx_data(m_data),
        .rx_valid(m_valid), .rx_ready(m_ready), .frame_err(m_ferr),
        .overrun(m_ovr), .rx_level(m_level)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   f_ferr_cnt = 0, f_ovr_cnt = 0, m_ferr_cnt = 0, m_ovr_cnt = 0;
    logic f_valid_q = 1'b0;
    time  f_rise_t = 0;
    time  stop_t = 0;
    logic [7:0] sb_f[$];
    logic [7:0] sb_m[$];

    // Pulse counters count high cycles, so a stretched pulse shows up as >1.
    always @(negedge clk_sys) begin
        f_ferr_cnt <= f_ferr_cnt + int'(f_ferr);
        f_ovr_cnt  <= f_ovr_cnt + int'(f_ovr);
        m_ferr_cnt <= m_ferr_cnt + int'(m_ferr);
        m_ovr_cnt  <= m_ovr_cnt + int'(m_ovr);
        f_valid_q  <= f_valid;
        if (f_valid && !f_valid_q) f_rise_t <= $time;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int inst, input logic v, input int clks);
        if (inst == 0) f_rx = v;
        else           m_rx = v;
        repeat (clks) @(negedge clk_sys);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] data, input logic stop_bit,
                              input int bclk);
        hold(inst, 1'b0, bclk);
        for (int i = 0; i < 8; i++) hold(inst, data[i], bclk);
        stop_t = $time;
        hold(inst, stop_bit, bclk);
    endtask

    task automatic send_byte(input int inst, input logic [7:0] data, input logic stop_bit,
                             input int bclk);
        send_frame(inst, data, stop_bit, bclk);
        hold(inst, 1'b1, 2 * bclk);
    endtask

    task automatic pop_check(input int inst, input string name);
        logic [7:0] exp;
        @(negedge clk_sys);
        if (inst == 0) begin
            exp = sb_f.pop_front();
            check({name, " valid"}, f_valid, 1);
            check({name, " data"}, f_data, exp);
            f_ready = 1'b1;
            @(negedge clk_sys);
            f_ready = 1'b0;
        end else begin
            exp = sb_m.pop_front();
            check({name, " valid"}, m_valid, 1);
            check({name, " data"}, m_data, exp);
            m_ready = 1'b1;
            @(negedge clk_sys);
            m_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         exp_level;
        int         exp_ovr;
        int         exp_ferr;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        int         ferr0, ovr0, lat;
        logic       seen;
        logic [7:0] exp_b;

        // Fill FIFO to depth with ready low, then an overrun and a framing error while full.
        tbl[0] = '{8'h01, 1'b1, 1, 0, 0};
        tbl[1] = '{8'h02, 1'b1, 2, 0, 0};
        tbl[2] = '{8'h03, 1'b1, 3, 0, 0};
        tbl[3] = '{8'h04, 1'b1, 4, 0, 0};
        tbl[4] = '{8'h05, 1'b1, 4, 1, 0};
        tbl[5] = '{8'hEE, 1'b0, 4, 0, 1};

        f_reset = 1'b1; m_reset = 1'b1;
        f_rx = 1'b1;    m_rx = 1'b1;
        f_ready = 1'b0; m_ready = 1'b0;
        repeat (5) @(negedge clk_sys);

        check("reset rx_data", f_data, 0);
        check("reset rx_valid", f_valid, 0);
        check("reset rx_level", f_level, 0);
        check("reset frame_err", f_ferr, 0);
        check("reset overrun", f_ovr, 0);
        check("reset midi rx_valid", m_valid, 0);
        f_reset = 1'b0; m_reset = 1'b0;
        hold(0, 1'b1, 2 * FAST_BIT);

        // T1: two back-to-back bytes, push latency relative to the stop bit
        send_byte(0, 8'h55, 1'b1, FAST_BIT);
        sb_f.push_back(8'h55);
        lat = int'((f_rise_t - stop_t) / 10);
        check("T1 valid rises after stop centre", (lat > FAST_BIT / 2 && lat < FAST_BIT), 1);
        send_byte(0, 8'hA3, 1'b1, FAST_BIT);
        sb_f.push_back(8'hA3);
        check("T1 level", f_level, 2);
        pop_check(0, "T1 pop0");
        pop_check(0, "T1 pop1");
        check("T1 level drained", f_level, 0);

        // T2: short low glitch on idle line
        ferr0 = f_ferr_cnt;
        hold(0, 1'b0, 8);
        hold(0, 1'b1, 2 * FAST_BIT);
        check("T2 level", f_level, 0);
        check("T2 frame_err pulses", f_ferr_cnt - ferr0, 0);
        check("T2 fsm idle", int'(dut_f.state), int'(IDLE));

        // T3: bad stop bit followed by a long break
        ferr0 = f_ferr_cnt;
        ovr0  = f_ovr_cnt;
        send_frame(0, 8'h3C, 1'b0, FAST_BIT);
        hold(0, 1'b0, 30 * FAST_BIT);
        hold(0, 1'b1, 3 * FAST_BIT);
        check("T3 frame_err pulses", f_ferr_cnt - ferr0, 1);
        check("T3 level", f_level, 0);
        check("T3 overrun pulses", f_ovr_cnt - ovr0, 0);

        // T4: table-driven fill beyond depth
        for (int i = 0; i < 6; i++) begin
            ferr0 = f_ferr_cnt;
            ovr0  = f_ovr_cnt;
            send_byte(0, tbl[i].data, tbl[i].stop_ok, FAST_BIT);
            if (tbl[i].stop_ok && tbl[i].exp_ovr == 0) sb_f.push_back(tbl[i].data);
            check($sformatf("T4[%0d] level", i), f_level, tbl[i].exp_level);
            check($sformatf("T4[%0d] overrun pulses", i), f_ovr_cnt - ovr0, tbl[i].exp_ovr);
            check($sformatf("T4[%0d] frame_err pulses", i), f_ferr_cnt - ferr0, tbl[i].exp_ferr);
        end

        // T5: push into full FIFO in the same cycle as a pop
        ovr0 = f_ovr_cnt;
        seen = 1'b0;
        fork
            send_byte(0, 8'h05, 1'b1, FAST_BIT);
            begin
                for (int k = 0; k < 12 * FAST_BIT && !seen; k++) begin
                    @(negedge clk_sys);
                    if (dut_f.push_stb) begin
                        exp_b = sb_f.pop_front();
                        check("T5 head at coincide", f_data, exp_b);
                        f_ready = 1'b1;
                        @(negedge clk_sys);
                        f_ready = 1'b0;
                        seen = 1'b1;
                    end
                end
            end
        join
        check("T5 coincide found", seen, 1);
        sb_f.push_back(8'h05);
        check("T5 level", f_level, 4);
        check("T5 overrun pulses", f_ovr_cnt - ovr0, 0);
        for (int i = 0; i < 4; i++) pop_check(0, $sformatf("T5 pop%0d", i));
        check("T5 level drained", f_level, 0);

        // T6: reset in the middle of data bit 4
        send_byte(0, 8'h11, 1'b1, FAST_BIT);
        sb_f.push_back(8'h11);
        check("T6 level before reset", f_level, 1);
        ferr0 = f_ferr_cnt;
        ovr0  = f_ovr_cnt;
        fork
            send_byte(0, 8'hF0, 1'b1, FAST_BIT);
            begin
                repeat (5 * FAST_BIT + FAST_BIT / 2) @(negedge clk_sys);
                check("T6 fsm in data", int'(dut_f.state), int'(DATA));
                f_reset = 1'b1;
                @(negedge clk_sys);
                check("T6 rx_data after reset", f_data, 0);
                check("T6 rx_valid after reset", f_valid, 0);
                check("T6 rx_level after reset", f_level, 0);
                f_reset = 1'b0;
            end
        join
        sb_f.delete();
        check("T6 frame_err pulses", f_ferr_cnt - ferr0, 0);
        check("T6 overrun pulses", f_ovr_cnt - ovr0, 0);
        check("T6 level after aborted frame", f_level, 0);
        send_byte(0, 8'h7E, 1'b1, FAST_BIT);
        sb_f.push_back(8'h7E);
        check("T6 level", f_level, 1);
        pop_check(0, "T6 pop");

        // T7: MIDI rate with +/-2% stimulus skew
        ferr0 = m_ferr_cnt;
        ovr0  = m_ovr_cnt;
        send_byte(1, 8'h90, 1'b1, MIDI_BIT + MIDI_BIT / 50);
        sb_m.push_back(8'h90);
        send_byte(1, 8'h3C, 1'b1, MIDI_BIT - MIDI_BIT / 50);
        sb_m.push_back(8'h3C);
        send_byte(1, 8'h7F, 1'b1, MIDI_BIT + MIDI_BIT / 50);
        sb_m.push_back(8'h7F);
        check("T7 level", m_level, 3);
        check("T7 frame_err pulses", m_ferr_cnt - ferr0, 0);
        check("T7 overrun pulses", m_ovr_cnt - ovr0, 0);
        for (int i = 0; i < 3; i++) pop_check(1, $sformatf("T7 pop%0d", i));
        check("T7 level drained", m_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
